// File: rtl/capture_pkg.sv
// Shared types and elaboration helpers for the sample capture checker.
package capture_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cap_state_e;

  // True when v is a non-zero power of two.
  function automatic bit is_pow2(input int unsigned v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/capture_fifo.sv
// Synchronous FIFO holding mismatch records; push while full is accepted
// only when a pop happens in the same cycle. Output is read straight from
// the storage registers, so a record is visible the cycle after its push.
module capture_fifo
  import capture_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  if (!is_pow2(DEPTH) || (DEPTH < 2)) begin : g_depth_chk
    $error("capture_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok;
  logic             pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign rdata_o = mem_q[rd_ptr_q];

  // Storage, pointers and occupancy; pointers wrap naturally (DEPTH is 2^AW).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW + 1)'(push_ok) - (AW + 1)'(pop_ok);
    end
  end

endmodule

// File: rtl/sample_capture_checker.sv
// Samples a DUT output bus at SAMPLE_FREQ, compares it with the reference,
// counts points/mismatches and queues mismatch records for valid/ready readout.
// Optional feature: define CAPTURE_MASK_EN to add a compare_mask input
// (bits at 0 are ignored by the compare; records keep full values).
module sample_capture_checker
  import capture_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned DUT_CLK_FREQ = 100_000_000,
  parameter int unsigned SAMPLE_FREQ  = 1_000_000,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  end_of_vector,
  input  logic [DATA_WIDTH-1:0] actual,
  input  logic [DATA_WIDTH-1:0] expected,
`ifdef CAPTURE_MASK_EN
  input  logic [DATA_WIDTH-1:0] compare_mask,
`endif
  output logic                  sample_tick,
  output logic                  rec_valid,
  input  logic                  rec_ready,
  output logic [CNT_WIDTH-1:0]  rec_index,
  output logic [DATA_WIDTH-1:0] rec_actual,
  output logic [DATA_WIDTH-1:0] rec_expected,
  output logic [CNT_WIDTH-1:0]  point_cnt,
  output logic [CNT_WIDTH-1:0]  mismatch_cnt,
  output logic                  overflow,
  output logic                  done
);

  localparam int unsigned      DIV      = DUT_CLK_FREQ / SAMPLE_FREQ;
  localparam int unsigned      DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  if (DIV < 2) begin : g_div_chk
    $error("sample_capture_checker: DUT_CLK_FREQ/SAMPLE_FREQ must be at least 2");
  end

  typedef struct packed {
    logic [CNT_WIDTH-1:0]  index;
    logic [DATA_WIDTH-1:0] act_val;
    logic [DATA_WIDTH-1:0] exp_val;
  } cap_rec_t;

  localparam int unsigned REC_W = $bits(cap_rec_t);

  cap_state_e           state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic                 tick_q, tick_d;
  logic [CNT_WIDTH-1:0] point_q, point_d;
  logic [CNT_WIDTH-1:0] mism_q, mism_d;
  logic                 ovf_q, ovf_d;
  logic                 done_q, done_d;

  logic [DATA_WIDTH-1:0] mask;
  logic                  miss;
  logic                  push;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  cap_rec_t              wrec;
  cap_rec_t              rrec;
  logic [REC_W-1:0]      rdata;

`ifdef CAPTURE_MASK_EN
  assign mask = compare_mask;
`else
  assign mask = '1;
`endif

  assign miss = |((actual ^ expected) & mask);
  assign pop  = !fifo_empty && rec_ready;
  assign rrec = cap_rec_t'(rdata);

  // Session FSM, sample divider, counters and record push decision.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    point_d = point_q;
    mism_d  = mism_q;
    ovf_d   = ovf_q;
    push    = 1'b0;
    wrec    = '{index: point_q, act_val: actual, exp_val: expected};
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = RUN;
          div_d   = '0;
          point_d = '0;
          mism_d  = '0;
          ovf_d   = 1'b0;
        end
      end
      RUN: begin
        if (!enable) begin
          state_d = IDLE;
          div_d   = '0;
        end else if (tick_q) begin
          div_d = '0;
          if (end_of_vector) begin
            state_d = DONE;
          end else begin
            point_d = (point_q == CNT_MAX) ? point_q : point_q + CNT_WIDTH'(1);
            if (miss) begin
              mism_d = (mism_q == CNT_MAX) ? mism_q : mism_q + CNT_WIDTH'(1);
              push   = 1'b1;
              if (fifo_full && !pop) ovf_d = 1'b1;
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      DONE: begin
        if (!enable) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    tick_d = (state_d == RUN) && (div_d == DIV_LAST);
    done_d = (state_d == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      tick_q  <= 1'b0;
      point_q <= '0;
      mism_q  <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      tick_q  <= tick_d;
      point_q <= point_d;
      mism_q  <= mism_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  capture_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (wrec),
    .pop_i   (pop),
    .rdata_o (rdata),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign sample_tick  = tick_q;
  assign rec_valid    = !fifo_empty;
  assign rec_index    = rrec.index;
  assign rec_actual   = rrec.act_val;
  assign rec_expected = rrec.exp_val;
  assign point_cnt    = point_q;
  assign mismatch_cnt = mism_q;
  assign overflow     = ovf_q;
  assign done         = done_q;

endmodule

// File: tb/tb_sample_capture_checker.sv
// Bench for sample_capture_checker with DIV=4 and a 4-entry record FIFO.
module tb_sample_capture_checker;

  localparam int unsigned DIV   = 4;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        end_of_vector = 1'b0;
  logic [15:0] actual = '0;
  logic [15:0] expected = '0;
  logic        rec_ready = 1'b0;
`ifdef CAPTURE_MASK_EN
  logic [15:0] compare_mask = 16'hFFFF;
`endif
  logic        sample_tick, rec_valid, overflow, done;
  logic [31:0] rec_index, point_cnt, mismatch_cnt;
  logic [15:0] rec_actual, rec_expected;

  sample_capture_checker #(
    .DATA_WIDTH   (16),
    .DUT_CLK_FREQ (8),
    .SAMPLE_FREQ  (2),
    .FIFO_DEPTH   (DEPTH),
    .CNT_WIDTH    (32)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .end_of_vector (end_of_vector),
    .actual        (actual),
    .expected      (expected),
`ifdef CAPTURE_MASK_EN
    .compare_mask  (compare_mask),
`endif
    .sample_tick   (sample_tick),
    .rec_valid     (rec_valid),
    .rec_ready     (rec_ready),
    .rec_index     (rec_index),
    .rec_actual    (rec_actual),
    .rec_expected  (rec_expected),
    .point_cnt     (point_cnt),
    .mismatch_cnt  (mismatch_cnt),
    .overflow      (overflow),
    .done          (done)
  );

  always #5 clk = ~clk;

  // Reference model: session phase, cycles spent running, counts and a record queue.
  typedef struct {
    logic [31:0] idx;
    logic [15:0] a;
    logic [15:0] e;
  } rec_t;

  rec_t        q[$];
  logic [31:0] popped[$];
  int          m_state = 0;      // 0 idle, 1 running, 2 finished
  int          m_runcyc = 0;
  logic [31:0] m_pts = '0;
  logic [31:0] m_mis = '0;
  logic        m_ovf = 1'b0;
  int          g_npts = 0;
  int          g_mode = 0;
  int          g_rdy = 0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_state = 0; m_runcyc = 0; m_pts = '0; m_mis = '0; m_ovf = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tick"}, 64'(sample_tick), 64'd0);
    chk({tag, "_valid"}, 64'(rec_valid), 64'd0);
    chk({tag, "_index"}, 64'(rec_index), 64'd0);
    chk({tag, "_ract"}, 64'(rec_actual), 64'd0);
    chk({tag, "_rexp"}, 64'(rec_expected), 64'd0);
    chk({tag, "_pts"}, 64'(point_cnt), 64'd0);
    chk({tag, "_mis"}, 64'(mismatch_cnt), 64'd0);
    chk({tag, "_ovf"}, 64'(overflow), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
  endtask

  // One clock: drive inputs at the falling edge, check, advance model and DUT.
  task automatic step();
    bit          tick_p, pop_p, push_p;
    logic [15:0] a, e, msk;
    rec_t        r;
    tick_p = (m_state == 1) && ((m_runcyc % DIV) == DIV - 1);
    case (g_mode)
      0: begin a = 16'h1234; e = 16'h1234; end
      1: begin
        if (m_pts == 32'd3 || m_pts == 32'd7) begin a = 16'h00FF; e = 16'h00FE; end
        else begin a = 16'h1234; e = 16'h1234; end
      end
      2: begin a = 16'h00FF; e = 16'h00FE; end
      3: begin
        a = 16'($urandom);
        e = ($urandom_range(0, 2) == 0) ? (a ^ (16'h1 << $urandom_range(0, 15))) : a;
      end
      default: begin a = 16'h12AB; e = 16'h12CD; end
    endcase
    actual = a;
    expected = e;
    end_of_vector = (m_pts == 32'(g_npts));
    case (g_rdy)
      0: rec_ready = 1'b0;
      1: rec_ready = 1'b1;
      2: rec_ready = (m_pts == 32'd4) && tick_p;
      default: rec_ready = 1'($urandom_range(0, 1));
    endcase
`ifdef CAPTURE_MASK_EN
    msk = compare_mask;
`else
    msk = 16'hFFFF;
`endif
    chk("tick", 64'(sample_tick), 64'(tick_p));
    chk("rec_valid", 64'(rec_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      chk("rec_index", 64'(rec_index), 64'(q[0].idx));
      chk("rec_actual", 64'(rec_actual), 64'(q[0].a));
      chk("rec_expected", 64'(rec_expected), 64'(q[0].e));
    end
    pop_p  = (q.size() != 0) && rec_ready;
    push_p = 1'b0;
    r = '{m_pts, a, e};
    case (m_state)
      0: if (enable) begin
        m_state = 1; m_runcyc = 0; m_pts = '0; m_mis = '0; m_ovf = 1'b0;
      end
      1: if (!enable) m_state = 0;
      else begin
        m_runcyc++;
        if (tick_p) begin
          if (end_of_vector) m_state = 2;
          else begin
            if (m_pts != 32'hFFFF_FFFF) m_pts++;
            if (((a ^ e) & msk) != 16'h0) begin
              if (m_mis != 32'hFFFF_FFFF) m_mis++;
              if (q.size() == DEPTH && !pop_p) m_ovf = 1'b1;
              else push_p = 1'b1;
            end
          end
        end
      end
      default: if (!enable) m_state = 0;
    endcase
    if (pop_p) begin
      popped.push_back(q[0].idx);
      void'(q.pop_front());
    end
    if (push_p) q.push_back(r);
    @(negedge clk);
    chk("point_cnt", 64'(point_cnt), 64'(m_pts));
    chk("mismatch_cnt", 64'(mismatch_cnt), 64'(m_mis));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("done", 64'(done), 64'(m_state == 2));
  endtask

  task automatic session(input int npts, input int mode, input int rdy);
    int cyc;
    g_npts = npts; g_mode = mode; g_rdy = rdy;
    enable = 1'b1;
    cyc = 0;
    while (m_state != 2 && cyc < 1000) begin
      step();
      cyc++;
    end
    chk("session_done", 64'(done), 64'd1);
  endtask

  task automatic idle(input int n, input int rdy);
    enable = 1'b0;
    g_rdy = rdy;
    repeat (n) step();
  endtask

  initial begin
    int n;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    idle(2, 0);

    // 1: clean run of 10 points
    session(10, 0, 0);
    chk("t1_pts", 64'(point_cnt), 64'd10);
    chk("t1_mis", 64'(mismatch_cnt), 64'd0);
    chk("t1_valid", 64'(rec_valid), 64'd0);
    idle(3, 0);

    // 2: mismatches at points 3 and 7, consumer always ready
    popped.delete();
    session(10, 1, 1);
    idle(4, 1);
    chk("t2_mis", 64'(mismatch_cnt), 64'd2);
    chk("t2_nrec", 64'(popped.size()), 64'd2);
    if (popped.size() == 2) begin
      chk("t2_idx0", 64'(popped[0]), 64'd3);
      chk("t2_idx1", 64'(popped[1]), 64'd7);
    end

    // 3: six mismatches with consumer stalled -> overflow
    popped.delete();
    session(6, 2, 0);
    chk("t3_ovf", 64'(overflow), 64'd1);
    chk("t3_mis", 64'(mismatch_cnt), 64'd6);
    chk("t3_valid", 64'(rec_valid), 64'd1);
    idle(6, 1);
    chk("t3_nrec", 64'(popped.size()), 64'd4);
    for (int i = 0; i < 4 && i < popped.size(); i++)
      chk("t3_idx", 64'(popped[i]), 64'(i));

    // 4: full FIFO popped in the same cycle as a push
    popped.delete();
    session(5, 2, 2);
    chk("t4_ovf", 64'(overflow), 64'd0);
    chk("t4_mis", 64'(mismatch_cnt), 64'd5);
    idle(6, 1);
    chk("t4_nrec", 64'(popped.size()), 64'd5);
    for (int i = 0; i < 5 && i < popped.size(); i++)
      chk("t4_idx", 64'(popped[i]), 64'(i));

    // 5: asynchronous reset between ticks, then restart
    g_npts = 1000; g_mode = 2; g_rdy = 0;
    enable = 1'b1;
    repeat (10) step();
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("t5_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    g_mode = 0;
    n = 0;
    while (sample_tick !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("t5_first_tick", 64'(n), 64'd4);
    step();
    chk("t5_pts", 64'(point_cnt), 64'd1);
    idle(3, 1);

`ifdef CAPTURE_MASK_EN
    // 6: masked compare ignores the low byte
    compare_mask = 16'hFF00;
    session(3, 4, 1);
    chk("t6_masked_mis", 64'(mismatch_cnt), 64'd0);
    idle(2, 1);
    compare_mask = 16'hFFFF;
    session(1, 4, 0);
    chk("t6_mis", 64'(mismatch_cnt), 64'd1);
    chk("t6_ract", 64'(rec_actual), 64'h12AB);
    chk("t6_rexp", 64'(rec_expected), 64'h12CD);
    chk("t6_idx", 64'(rec_index), 64'd0);
    idle(3, 1);
`endif

    // Random data and random consumer back-pressure
    for (int s = 0; s < 3; s++) begin
      session(20, 3, 3);
      idle(8, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
